pc_if_queue: RTL and testbench
==============================

# pc_if_queue

Parametrised, multi-entry pipeline buffer between the PC stage and the IF stage. It carries the fetch packet `{pc, is_branch_taken, pht_index}` in order through a DEPTH-entry circular queue. When the next stage stalls, the PC stage can keep running until the queue fills, instead of every stall propagating back in lock-step. Flush discards all buffered packets in one cycle. When the queue is empty, the output presents an invalid packet.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of `pc_in`/`pc_out`.
- `GHR_WIDTH`, 8: width of `pht_index_in`/`pht_index_out`.
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `INVALID_PC`, 0: value driven on `pc_out` when the queue is empty or in reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  discard all entries this cycle.
- `stall_current_stage`  in  1  PC stage stalled; no packet offered this cycle.
- `stall_next_stage`  in  1  IF stage cannot accept the head packet this cycle.
- `is_branch_taken_in`  in  1  prediction bit of the offered packet.
- `pht_index_in`  in  GHR_WIDTH  PHT index of the offered packet.
- `pc_in`  in  ADDR_WIDTH  PC of the offered packet.
- `valid_out`  out  1  head packet present.
- `is_branch_taken_out`  out  1  head prediction bit; 0 when empty.
- `pht_index_out`  out  GHR_WIDTH  head PHT index; 0 when empty.
- `pc_out`  out  ADDR_WIDTH  head PC; `INVALID_PC` when empty.
- `full`  out  1  `count == DEPTH`; the PC stage must stall.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `overflow`  out  1  sticky error: a push was offered while full and no pop occurred.

## Operation
- State: storage array `mem[DEPTH]`, `wr_ptr`, `rd_ptr` (each $clog2(DEPTH) bits, wrapping modulo DEPTH), `count`, `overflow`.
- Define the per-cycle events:
  - `pop = !stall_next_stage && count != 0`
  - `push_req = !stall_current_stage`
  - `push = push_req && (count != DEPTH || pop)`
- Priority: `rst` > `flush` > push/pop.
- `rst` (asynchronous): `wr_ptr = rd_ptr = count = 0` and `overflow = 0`. Storage contents are don't-care.
- `flush` (synchronous): same clearing as reset. Any push and pop in that cycle are ignored; no packet is delivered.
- On push: `mem[wr_ptr] <= {is_branch_taken_in, pht_index_in, pc_in}` and `wr_ptr <= wr_ptr + 1`.
- On pop: `rd_ptr <= rd_ptr + 1`.
- `count` update: `count <= count + push - pop`. Simultaneous push and pop leave `count` unchanged. This holds at full, giving full throughput with DEPTH entries occupied.
- Simultaneous push and pop with `count == 1`: the head is consumed and the new entry becomes the head next cycle.
- Overflow: when `push_req && count == DEPTH && !pop`, the packet is dropped and `overflow <= 1`. Nothing else changes.
- Outputs: `valid_out = (count != 0)`. When valid, the out fields equal `mem[rd_ptr]`; otherwise they take the invalid values listed in the interface.
- `full` and `count` are decoded from registered state only, with no combinational path from the inputs.

## Timing
- Reset values: `valid_out = 0`, `pc_out = INVALID_PC`, `is_branch_taken_out = 0`, `pht_index_out = 0`, `full = 0`, `count = 0`, `overflow = 0`.
- Latency: a packet pushed at edge N appears on the outputs after edge N, when it is the head. There is no same-cycle bypass into an empty queue.
- Throughput: one push and one pop per cycle in every occupancy state.
- The head packet is held stable while `stall_next_stage = 1`.
- Flush asserted in cycle N: after edge N the queue is empty and the outputs are invalid. A push in cycle N+1 is accepted normally.
- `rst` asserted mid-operation: the outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset with queue contents present: assert `rst` between edges -> outputs go to reset values immediately, including `pc_out = INVALID_PC` and `count = 0`.
- Fill: `stall_next_stage = 1`, push PCs 0x100, 0x104, 0x108, 0x10C -> `count` goes 1..4, `full = 1`, head stays at `pc_out = 0x100`. A fifth push 0x110 -> dropped, `overflow = 1`.
- Full throughput at full: with 4 entries held, release the stall and push one packet per cycle -> outputs 0x100, 0x104, … in order. `count` stays 4, `overflow` does not newly assert.
- Wrap-around: stream 10 packets (0x200 + 4·i) with random next-stage stalls -> outputs in exact order across pointer wrap, with `pht_index` and taken bit matching per packet.
- Flush: with 3 entries buffered, assert `flush` together with a push of 0x300 -> next cycle `count = 0`, `valid_out = 0`, 0x300 not stored, `overflow` cleared.
- Single-entry push and pop: with `count = 1` (head 0x400), push 0x404 and pop in the same cycle -> next cycle `count = 1`, `pc_out = 0x404`.

Source files
------------

// File: rtl/pc_if_queue.sv
// pc_if_queue
//   In-order circular queue that carries fetch packets {pc, is_branch_taken,
//   pht_index} from the PC stage to the IF stage. It lets the PC stage keep
//   running through short IF stalls until DEPTH packets are buffered.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         drop every buffered packet this cycle
//   stall_current_stage           PC stage offers no packet this cycle
//   stall_next_stage              IF stage will not take the head this cycle
//   is_branch_taken_in, pht_index_in, pc_in   offered packet
//   valid_out, is_branch_taken_out, pht_index_out, pc_out   head packet
//   full, count                   occupancy, decoded from registered state only
//   overflow                      sticky: a packet was offered and dropped while full
module pc_if_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_WIDTH  = 8,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] INVALID_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall_current_stage,
  input  logic                       stall_next_stage,
  input  logic                       is_branch_taken_in,
  input  logic [GHR_WIDTH-1:0]       pht_index_in,
  input  logic [ADDR_WIDTH-1:0]      pc_in,
  output logic                       valid_out,
  output logic                       is_branch_taken_out,
  output logic [GHR_WIDTH-1:0]       pht_index_out,
  output logic [ADDR_WIDTH-1:0]      pc_out,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + GHR_WIDTH + ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic empty;
  logic is_full;
  logic pop;
  logic push_req;
  logic push;

  assign empty    = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign pop      = !stall_next_stage && !empty;
  assign push_req = !stall_current_stage;
  // A full queue still accepts a packet when the head leaves in the same cycle.
  assign push     = push_req && (!is_full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push_req && is_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; stale entries are never visible because the
  // outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {is_branch_taken_in, pht_index_in, pc_in};
  end

  logic [EW-1:0] head;
  assign head = mem[rd_ptr];

  always_comb begin
    valid_out           = !empty;
    is_branch_taken_out = 1'b0;
    pht_index_out       = '0;
    pc_out              = INVALID_PC;
    if (!empty) begin
      is_branch_taken_out = head[EW-1];
      pht_index_out       = head[ADDR_WIDTH +: GHR_WIDTH];
      pc_out              = head[ADDR_WIDTH-1:0];
    end
  end

  assign full     = is_full;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pc_if_queue.sv
module tb_pc_if_queue;

  localparam int AW = 32;
  localparam int GW = 8;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] INV_PC = 32'hFFFF_FFF0;

  typedef struct packed {
    logic          tk;
    logic [GW-1:0] ph;
    logic [AW-1:0] pc;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stall_current_stage;
  logic          stall_next_stage;
  logic          is_branch_taken_in;
  logic [GW-1:0] pht_index_in;
  logic [AW-1:0] pc_in;
  logic          valid_out;
  logic          is_branch_taken_out;
  logic [GW-1:0] pht_index_out;
  logic [AW-1:0] pc_out;
  logic          full;
  logic [2:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  pkt_t mq[$];
  logic m_ovf;

  always #5 clk = ~clk;

  pc_if_queue #(
    .ADDR_WIDTH(AW), .GHR_WIDTH(GW), .DEPTH(DEPTH), .INVALID_PC(INV_PC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_current_stage(stall_current_stage),
    .stall_next_stage(stall_next_stage),
    .is_branch_taken_in(is_branch_taken_in),
    .pht_index_in(pht_index_in), .pc_in(pc_in),
    .valid_out(valid_out), .is_branch_taken_out(is_branch_taken_out),
    .pht_index_out(pht_index_out), .pc_out(pc_out),
    .full(full), .count(count), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic          ev;
    logic          etk;
    logic [GW-1:0] eph;
    logic [AW-1:0] epc;
    ev = (mq.size() != 0);
    etk = 1'b0; eph = '0; epc = INV_PC;
    if (ev) begin
      etk = mq[0].tk; eph = mq[0].ph; epc = mq[0].pc;
    end
    chk({ctx, ".valid"},    32'(valid_out), 32'(ev));
    chk({ctx, ".pc"},       pc_out, epc);
    chk({ctx, ".taken"},    32'(is_branch_taken_out), 32'(etk));
    chk({ctx, ".pht"},      32'(pht_index_out), 32'(eph));
    chk({ctx, ".count"},    32'(count), 32'(mq.size()));
    chk({ctx, ".full"},     32'(full), 32'(mq.size() == DEPTH));
    chk({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Queue-level reference: head leaves if the consumer is ready, a new
  // packet joins if there is (or is about to be) room, otherwise it is lost.
  task automatic model_edge(input logic fl, input logic sc, input logic sn, input pkt_t p);
    bit did_pop;
    int sz;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
      return;
    end
    sz = mq.size();
    did_pop = !sn && sz > 0;
    if (did_pop) void'(mq.pop_front());
    if (!sc) begin
      if (sz < DEPTH || did_pop) mq.push_back(p);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input string ctx, input logic fl, input logic sc, input logic sn,
                      input logic tk, input logic [GW-1:0] ph, input logic [AW-1:0] pcv);
    pkt_t p;
    flush = fl; stall_current_stage = sc; stall_next_stage = sn;
    is_branch_taken_in = tk; pht_index_in = ph; pc_in = pcv;
    p.tk = tk; p.ph = ph; p.pc = pcv;
    @(posedge clk);
    model_edge(fl, sc, sn, p);
    #1;
    check_outputs(ctx);
  endtask

  function automatic logic would_accept(input logic sc, input logic sn);
    return !sc && (mq.size() < DEPTH || (!sn && mq.size() > 0));
  endfunction

  initial begin
    logic sn;
    logic tk;
    logic [GW-1:0] ph;
    int i;
    int guard;

    rst = 1'b1; flush = 1'b0; stall_current_stage = 1'b1; stall_next_stage = 1'b1;
    is_branch_taken_in = 1'b0; pht_index_in = '0; pc_in = '0;
    m_ovf = 1'b0;
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset with contents present
    step("pre_rst0", 0, 0, 1, 1, 8'h11, 32'h10);
    step("pre_rst1", 0, 0, 1, 0, 8'h12, 32'h14);
    #2;
    rst = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Fill with the consumer stalled; head must stay at 0x100
    for (int k = 0; k < 4; k++)
      step("fill", 0, 0, 1, k[0], 8'(8'h20 + k), 32'h100 + 32'(4 * k));
    step("overflow_push", 0, 0, 1, 1, 8'h24, 32'h110);

    // Full throughput while full
    for (int k = 0; k < 6; k++)
      step("thru_full", 0, 0, 0, k[1], 8'(8'h30 + k), 32'h114 + 32'(4 * k));

    // Flush with a concurrent push
    step("flush_clear", 1, 1, 1, 0, 8'h0, 32'h0);
    for (int k = 0; k < 3; k++)
      step("pre_flush", 0, 0, 1, 1, 8'(8'h40 + k), 32'h2F0 + 32'(4 * k));
    step("flush_push", 1, 0, 0, 1, 8'h55, 32'h300);
    step("after_flush", 0, 1, 1, 0, 8'h0, 32'h0);

    // Simultaneous push and pop at count == 1
    step("single_fill", 0, 0, 1, 0, 8'h60, 32'h400);
    step("single_pp", 0, 0, 0, 1, 8'h61, 32'h404);
    step("single_hold", 0, 1, 1, 0, 8'h0, 32'h0);
    step("single_drain", 0, 1, 0, 0, 8'h0, 32'h0);

    // Wrap-around stream with random consumer stalls
    i = 0; guard = 0;
    while (i < 10 && guard < 200) begin
      sn = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      ph = 8'($urandom);
      if (would_accept(1'b0, sn)) begin
        step("wrap", 0, 0, sn, tk, ph, 32'h200 + 32'(4 * i));
        i++;
      end else begin
        step("wrap_wait", 0, 0, sn, tk, ph, 32'h200 + 32'(4 * i));
      end
      guard++;
    end
    chk("wrap_all_pushed", 32'(i), 32'd10);
    guard = 0;
    while (mq.size() != 0 && guard < 100) begin
      step("wrap_drain", 0, 1, 1'($urandom_range(0, 1)), 0, 8'h0, 32'h0);
      guard++;
    end
    chk("wrap_drained", 32'(count), 32'd0);

    // Random mix including overflow and flush
    for (int k = 0; k < 300; k++)
      step("random", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), 1'($urandom), 8'($urandom), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
